// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// CHECKSUM_EN adds the trailing checksum state to the frame parser.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
`ifdef CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LEN_MIN   = 8'd1;
  localparam logic [7:0] LEN_MAX   = 8'd255;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while run is high, restarts on kick,
// and flags expired on the cycle that completes TIMEOUT_CYC silent cycles.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_reg;

  assign expired = run && !kick && (cnt_reg == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || kick || !run) begin
      cnt_reg <= '0;
    end else if (!expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a framed program over UART bytes and writes it into BSRAM while the CPU is held.
// CHECKSUM_EN enables a trailing XOR checksum byte that must match before the CPU restarts.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [15:0]       mem_din,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              busy,
  output logic              err
);

  state_t              state_reg;
  logic [7:0]          len_reg;
  logic [7:0]          idx_reg;
  logic [7:0]          hi_reg;
  logic [7:0]          csum_reg;
  logic [ADDR_W-1:0]   wr_ad_reg;
  logic [15:0]         din_reg;
  logic                wre_reg;
  logic                hold_reg;
  logic                restart_reg;
  logic                busy_reg;
  logic                err_reg;
  logic                run;
  logic                expired;
  logic                last_word;

  assign run = (state_reg == ST_LEN) || (state_reg == ST_HI) || (state_reg == ST_LO)
`ifdef CHECKSUM_EN
            || (state_reg == ST_CSUM)
`endif
            ;

  assign last_word = (8'(idx_reg + 8'd1) == len_reg);

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .kick    (rx_valid),
    .run     (run),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      idx_reg     <= '0;
      hi_reg      <= '0;
      csum_reg    <= '0;
      wr_ad_reg   <= '0;
      din_reg     <= '0;
      wre_reg     <= 1'b0;
      hold_reg    <= 1'b0;
      restart_reg <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      wre_reg     <= 1'b0;
      restart_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_ERR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_reg <= ST_LEN;
            hold_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            err_reg   <= 1'b0;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            if (rx_data < LEN_MIN || rx_data > LEN_MAX) begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              len_reg   <= rx_data;
              idx_reg   <= '0;
              csum_reg  <= rx_data;
              state_reg <= ST_HI;
            end
          end else if (expired) begin
            state_reg <= ST_ERR;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        ST_HI: begin
          if (rx_valid) begin
            hi_reg    <= rx_data;
            csum_reg  <= csum_reg ^ rx_data;
            state_reg <= ST_LO;
          end else if (expired) begin
            state_reg <= ST_ERR;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        ST_LO: begin
          if (rx_valid) begin
            // The write is launched here and lands on the following cycle.
            wre_reg   <= 1'b1;
            din_reg   <= {hi_reg, rx_data};
            wr_ad_reg <= ADDR_W'(idx_reg);
            idx_reg   <= idx_reg + 8'd1;
            csum_reg  <= csum_reg ^ rx_data;
            if (!last_word) begin
              state_reg <= ST_HI;
            end else begin
`ifdef CHECKSUM_EN
              state_reg <= ST_CSUM;
`else
              state_reg   <= ST_DONE;
              hold_reg    <= 1'b0;
              restart_reg <= 1'b1;
              busy_reg    <= 1'b0;
`endif
            end
          end else if (expired) begin
            state_reg <= ST_ERR;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM: begin
          if (rx_valid) begin
            busy_reg <= 1'b0;
            if (rx_data == csum_reg) begin
              state_reg   <= ST_DONE;
              hold_reg    <= 1'b0;
              restart_reg <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
            end
          end else if (expired) begin
            state_reg <= ST_ERR;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
`endif
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The CPU owns the address bus except during the single write cycle.
  assign mem_ad      = wre_reg ? wr_ad_reg : cpu_addr;
  assign mem_ce      = 1'b1;
  assign mem_wre     = wre_reg;
  assign mem_din     = din_reg;
  assign cpu_hold    = hold_reg;
  assign cpu_restart = restart_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; expected BSRAM writes come from the frame contents.
// Define CHECKSUM_EN to exercise the checksum variant.
module tb_prog_loader;

  localparam int ADDR_W = 11;
  localparam int TO     = 40;

  typedef logic [ADDR_W+15:0] wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [15:0]       mem_din;
  logic              cpu_hold;
  logic              cpu_restart;
  logic              busy;
  logic              err;

  int tests_run    = 0;
  int tests_failed = 0;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [15:0] words [0:255];
  int          wre_run     = 0;
  int          max_wre_run = 0;
  int          restart_cnt = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cpu_addr    (cpu_addr),
    .mem_ce      (mem_ce),
    .mem_wre     (mem_wre),
    .mem_ad      (mem_ad),
    .mem_din     (mem_din),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .busy        (busy),
    .err         (err)
  );

  // Observe the memory port and restart pulses on the inactive edge.
  always @(negedge clk) begin
    if (mem_wre) begin
      got_q.push_back({mem_ad, mem_din});
      wre_run = wre_run + 1;
      if (wre_run > max_wre_run) max_wre_run = wre_run;
    end else begin
      wre_run = 0;
    end
    if (cpu_restart) restart_cnt = restart_cnt + 1;
  end

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    max_wre_run = 0;
    restart_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends one well-formed frame from words[] and records the writes it must cause.
  task automatic send_frame(input int len, input int gap_max);
    logic [7:0] cs;
    cs = 8'(len);
    send_byte(8'hA5);
    idle($urandom_range(gap_max, 0));
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      idle($urandom_range(gap_max, 0));
      send_byte(words[i][15:8]);
      idle($urandom_range(gap_max, 0));
      send_byte(words[i][7:0]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
      exp_q.push_back({ADDR_W'(i), words[i]});
    end
`ifdef CHECKSUM_EN
    idle($urandom_range(gap_max, 0));
    send_byte(cs);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    cpu_addr = ADDR_W'($urandom);
    idle(3);
    tests_run++;
    if ({mem_wre, mem_ce, mem_din, cpu_hold, cpu_restart, busy, err} !== {1'b0, 1'b1, 16'h0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_outputs got wre=%b ce=%b din=%h hold=%b rst=%b busy=%b err=%b want 0 1 0000 0 0 0 0",
               mem_wre, mem_ce, mem_din, cpu_hold, cpu_restart, busy, err);
    end
    tests_run++;
    if (mem_ad !== cpu_addr) begin
      tests_failed++;
      $display("FAIL reset_mem_ad got %h want %h", mem_ad, cpu_addr);
    end
    rst = 1'b0;
    idle(1);
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    clear_mon();
    words[0] = 16'h1234;
    words[1] = 16'h5678;
    send_frame(2, 0);
    idle(4);
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL basic_write[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (max_wre_run !== 1) begin
      tests_failed++;
      $display("FAIL basic_wre_width got %0d want 1", max_wre_run);
    end
    tests_run++;
    if ({restart_cnt, cpu_hold, busy, err} !== {32'd1, 3'b000}) begin
      tests_failed++;
      $display("FAIL basic_done got restarts=%0d hold=%b busy=%b err=%b want 1 0 0 0",
               restart_cnt, cpu_hold, busy, err);
    end
    cpu_addr = ADDR_W'($urandom);
    #1;
    tests_run++;
    if (mem_ad !== cpu_addr) begin
      tests_failed++;
      $display("FAIL basic_mem_ad got %h want %h", mem_ad, cpu_addr);
    end
    $display("[TB] basic frame: %0d writes", got_q.size());
  endtask

  task automatic test_len_zero();
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(3);
    tests_run++;
    if ({err, cpu_hold, busy} !== 3'b110 || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL len_zero got err=%b hold=%b busy=%b writes=%0d want 1 1 0 0",
               err, cpu_hold, busy, got_q.size());
    end
    words[0] = 16'hABCD;
    send_frame(1, 1);
    idle(4);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL len_zero_recover got n=%0d first=%h want 1 %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : wr_t'(0), exp_q[0]);
    end
    tests_run++;
    if ({err, cpu_hold, restart_cnt} !== {2'b00, 32'd1}) begin
      tests_failed++;
      $display("FAIL len_zero_clear got err=%b hold=%b restarts=%0d want 0 0 1", err, cpu_hold, restart_cnt);
    end
    $display("[TB] zero-length frame then recovery");
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    tests_run++;
    if ({cpu_hold, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL timeout_loading got hold=%b busy=%b want 1 1", cpu_hold, busy);
    end
    idle(TO - 2);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early got err=%b want 0", err);
    end
    idle(4);
    tests_run++;
    if ({err, cpu_hold, busy} !== 3'b110 || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL timeout_err got err=%b hold=%b busy=%b writes=%0d want 1 1 0 0",
               err, cpu_hold, busy, got_q.size());
    end
    $display("[TB] inter-byte timeout");
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    send_frame(3, 0);
    idle(4);
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL b2b_write[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    $display("[TB] back-to-back frame: %0d writes", got_q.size());
  endtask

  task automatic test_random();
    int lens[6];
    clear_mon();
    lens = '{0, 0, 0, 0, 0, 255};
    for (int f = 0; f < 6; f++) begin
      if (f < 5) lens[f] = $urandom_range(12, 1);
      for (int i = 0; i < lens[f]; i++) words[i] = 16'($urandom);
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        logic [7:0] junk;
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      send_frame(lens[f], (f < 5) ? 3 : 0);
      idle(4);
      $display("[TB] random frame %0d len %0d", f, lens[f]);
    end
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL random_write[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if ({restart_cnt, err, max_wre_run} !== {32'd6, 1'b0, 32'd1}) begin
      tests_failed++;
      $display("FAIL random_status got restarts=%0d err=%b wre_width=%0d want 6 0 1",
               restart_cnt, err, max_wre_run);
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    idle(4);
    tests_run++;
    if ({restart_cnt, err, cpu_hold} !== {32'd1, 2'b00} || got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL csum_good got restarts=%0d err=%b hold=%b writes=%0d want 1 0 0 1",
               restart_cnt, err, cpu_hold, got_q.size());
    end
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    idle(4);
    tests_run++;
    if ({restart_cnt, err, cpu_hold} !== {32'd0, 2'b11}) begin
      tests_failed++;
      $display("FAIL csum_bad got restarts=%0d err=%b hold=%b want 0 1 1", restart_cnt, err, cpu_hold);
    end
    $display("[TB] checksum good and bad");
  endtask
`endif

  task automatic test_reset_mid();
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    cpu_addr = ADDR_W'($urandom);
    rst = 1'b1;
    idle(1);
    tests_run++;
    if ({mem_wre, mem_ce, mem_din, cpu_hold, cpu_restart, busy, err} !== {1'b0, 1'b1, 16'h0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got wre=%b ce=%b din=%h hold=%b rst=%b busy=%b err=%b want 0 1 0000 0 0 0 0",
               mem_wre, mem_ce, mem_din, cpu_hold, cpu_restart, busy, err);
    end
    tests_run++;
    if (mem_ad !== cpu_addr) begin
      tests_failed++;
      $display("FAIL mid_reset_mem_ad got %h want %h", mem_ad, cpu_addr);
    end
    rst = 1'b0;
    send_byte(8'h34);
    idle(4);
    tests_run++;
    if (got_q.size() != 0 || {busy, cpu_hold, restart_cnt} !== {2'b00, 32'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset_abandon got writes=%0d busy=%b hold=%b restarts=%0d want 0 0 0 0",
               got_q.size(), busy, cpu_hold, restart_cnt);
    end
    $display("[TB] reset mid-load");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_timeout();
    test_back_to_back();
    test_random();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
